center_overlay: RTL and testbench



---
 rtl/center_overlay_pkg.sv | 24 ++
 rtl/center_smoother.sv | 108 ++++++++++
 rtl/center_overlay.sv | 82 ++++++++
 tb/tb_center_overlay.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/center_overlay_pkg.sv
// Shared types and constants for the centre overlay: tracking states,
// overlay colours, the tracker's "no target" default and coordinate width.
package center_overlay_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCK   = 2'd1,
    ST_HOLD   = 2'd2
  } track_state_t;

  localparam logic [23:0] COLOR_LOCK = 24'h00FF00;
  localparam logic [23:0] COLOR_HOLD = 24'hFFFF00;

  localparam logic [COORD_W-1:0] NO_TARGET_H = 12'd320;
  localparam logic [COORD_W-1:0] NO_TARGET_V = 12'd240;

  // Magnitude of a 13-bit signed coordinate difference (range never hits -4096).
  function automatic logic [COORD_W:0] abs13(input logic signed [COORD_W:0] v);
    return v[COORD_W] ? (COORD_W+1)'(-v) : (COORD_W+1)'(v);
  endfunction

endpackage

// File: rtl/center_smoother.sv
// Per-frame SEARCH/LOCK/HOLD tracker with an IIR-smoothed marker position.
// Everything advances only on the frame tick; centre inputs are ignored otherwise.
module center_smoother
  import center_overlay_pkg::*;
#(
  parameter int LOST_FRAMES  = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               tick,
  input  logic [COORD_W-1:0] center_h,
  input  logic [COORD_W-1:0] center_v,
  output logic [COORD_W-1:0] marker_h,
  output logic [COORD_W-1:0] marker_v,
  output track_state_t       state
);

  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [MISS_W-1:0] LOST = MISS_W'(LOST_FRAMES);

  track_state_t       state_reg, state_next;
  logic               hit_reg, hit_next;
  logic [MISS_W-1:0]  miss_reg, miss_next;
  logic [COORD_W-1:0] marker_h_reg, marker_h_next;
  logic [COORD_W-1:0] marker_v_reg, marker_v_next;
  logic               target_valid;

  // The step lies between marker and centre, so 12-bit truncation never wraps.
  function automatic logic [COORD_W-1:0] smooth(input logic [COORD_W-1:0] marker,
                                                 input logic [COORD_W-1:0] centre);
    logic signed [COORD_W:0] diff;
    logic signed [COORD_W:0] step;
    diff = $signed({1'b0, centre}) - $signed({1'b0, marker});
    step = diff >>> SMOOTH_SHIFT;
    return marker + step[COORD_W-1:0];
  endfunction

  assign target_valid = (center_h != NO_TARGET_H) || (center_v != NO_TARGET_V);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= ST_SEARCH;
      hit_reg      <= 1'b0;
      miss_reg     <= '0;
      marker_h_reg <= NO_TARGET_H;
      marker_v_reg <= NO_TARGET_V;
    end else begin
      state_reg    <= state_next;
      hit_reg      <= hit_next;
      miss_reg     <= miss_next;
      marker_h_reg <= marker_h_next;
      marker_v_reg <= marker_v_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hit_next      = hit_reg;
    miss_next     = miss_reg;
    marker_h_next = marker_h_reg;
    marker_v_next = marker_v_reg;
    if (tick) begin
      case (state_reg)
        ST_SEARCH: begin
          if (!target_valid) begin
            hit_next = 1'b0;
          end else if (hit_reg) begin
            state_next    = ST_LOCK;
            hit_next      = 1'b0;
            marker_h_next = center_h;
            marker_v_next = center_v;
          end else begin
            hit_next = 1'b1;
          end
        end
        ST_LOCK: begin
          if (target_valid) begin
            marker_h_next = smooth(marker_h_reg, center_h);
            marker_v_next = smooth(marker_v_reg, center_v);
          end else begin
            state_next = ST_HOLD;
            miss_next  = MISS_W'(1);
          end
        end
        ST_HOLD: begin
          if (target_valid) begin
            state_next    = ST_LOCK;
            miss_next     = '0;
            marker_h_next = smooth(marker_h_reg, center_h);
            marker_v_next = smooth(marker_v_reg, center_v);
          end else if (miss_reg + 1'b1 == LOST) begin
            state_next = ST_SEARCH;
            miss_next  = '0;
          end else begin
            miss_next = miss_reg + 1'b1;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  assign marker_h = marker_h_reg;
  assign marker_v = marker_v_reg;
  assign state    = state_reg;

endmodule

// File: rtl/center_overlay.sv
// Draws the tracked centre (crosshair, plus box when locked) onto the pixel
// stream with one cycle of latency; blanking and SEARCH pass rgb_in through.
module center_overlay
  import center_overlay_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ARM_LEN      = 16,
  parameter int BOX_HALF     = 32,
  parameter int LOST_FRAMES  = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] Hcnt,
  input  logic [COORD_W-1:0] Vcnt,
  input  logic [COORD_W-1:0] center_h,
  input  logic [COORD_W-1:0] center_v,
  input  logic [23:0]        rgb_in,
  output logic [23:0]        rgb_out,
  output logic [COORD_W-1:0] marker_h,
  output logic [COORD_W-1:0] marker_v,
  output logic               tracking
);

  localparam logic [COORD_W:0] ARM = (COORD_W+1)'(ARM_LEN);
  localparam logic [COORD_W:0] BOX = (COORD_W+1)'(BOX_HALF);

  track_state_t            track_state;
  logic                    frame_tick;
  logic                    in_active;
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]        adx, ady;
  logic                    on_cross, on_box;
  logic [23:0]             rgb_next, rgb_reg;

  // Tick at Hcnt==1 so the updated marker is live from Hcnt==2 of line 0.
  assign frame_tick = (Hcnt == 12'd1) && (Vcnt == 12'd0);

  center_smoother #(
    .LOST_FRAMES (LOST_FRAMES),
    .SMOOTH_SHIFT(SMOOTH_SHIFT)
  ) u_smoother (
    .clk     (pclk),
    .srst    (rst),
    .tick    (frame_tick),
    .center_h(center_h),
    .center_v(center_v),
    .marker_h(marker_h),
    .marker_v(marker_v),
    .state   (track_state)
  );

  assign in_active = (Hcnt < COORD_W'(H_ACTIVE)) && (Vcnt < COORD_W'(V_ACTIVE));
  assign dx  = $signed({1'b0, Hcnt} - {1'b0, marker_h});
  assign dy  = $signed({1'b0, Vcnt} - {1'b0, marker_v});
  assign adx = abs13(dx);
  assign ady = abs13(dy);

  assign on_cross = ((dy == 0) && (adx <= ARM)) || ((dx == 0) && (ady <= ARM));
  assign on_box   = ((adx == BOX) && (ady <= BOX)) || ((ady == BOX) && (adx <= BOX));

  always_comb begin
    rgb_next = rgb_in;
    if (in_active) begin
      case (track_state)
        ST_LOCK: if (on_cross || on_box) rgb_next = COLOR_LOCK;
        ST_HOLD: if (on_cross)           rgb_next = COLOR_HOLD;
        default: rgb_next = rgb_in;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) rgb_reg <= '0;
    else     rgb_reg <= rgb_next;
  end

  assign rgb_out  = rgb_reg;
  assign tracking = (track_state != ST_SEARCH);

endmodule

// File: tb/tb_center_overlay.sv
// Directed bench for center_overlay: frame ticks are driven explicitly, then
// individual pixels are probed against hand-computed colours and markers.
module tb_center_overlay;

  localparam logic [23:0] PIX    = 24'h123456;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] YELLOW = 24'hFFFF00;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] Hcnt, Vcnt, center_h, center_v;
  logic [23:0] rgb_in, rgb_out;
  logic [11:0] marker_h, marker_v;
  logic        tracking;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  center_overlay dut (
    .pclk    (pclk),
    .rst     (rst),
    .Hcnt    (Hcnt),
    .Vcnt    (Vcnt),
    .center_h(center_h),
    .center_v(center_v),
    .rgb_in  (rgb_in),
    .rgb_out (rgb_out),
    .marker_h(marker_h),
    .marker_v(marker_v),
    .tracking(tracking)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One frame tick with the given centre; leaves Hcnt at 2 so it cannot retick.
  task automatic tick(input logic [11:0] ch, input logic [11:0] cv);
    @(negedge pclk);
    Hcnt = 12'd1; Vcnt = 12'd0; center_h = ch; center_v = cv; rgb_in = PIX;
    @(posedge pclk); #1;
    $display("tick centre=(%0d,%0d) marker=(%0d,%0d) tracking=%0b",
             ch, cv, marker_h, marker_v, tracking);
    @(negedge pclk);
    Hcnt = 12'd2;
  endtask

  task automatic pixel(input string tag, input logic [11:0] h, input logic [11:0] v,
                       input logic [23:0] exp);
    @(negedge pclk);
    Hcnt = h; Vcnt = v; rgb_in = PIX;
    @(posedge pclk); #1;
    $display("pixel %s (%0d,%0d) rgb_out=%06h", tag, h, v, rgb_out);
    check(tag, rgb_out, exp);
  endtask

  task automatic check_marker(input string tag, input logic [11:0] h,
                              input logic [11:0] v, input logic trk);
    check({tag, "_mh"}, marker_h, h);
    check({tag, "_mv"}, marker_v, v);
    check({tag, "_trk"}, tracking, trk);
  endtask

  initial begin
    rst = 1'b1; Hcnt = 12'd5; Vcnt = 12'd5; center_h = 12'd320; center_v = 12'd240;
    rgb_in = PIX;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_rgb", rgb_out, 24'h0);
    check_marker("reset", 12'd320, 12'd240, 1'b0);
    @(negedge pclk); rst = 1'b0;

    // No-target frames keep SEARCH and pass the stream through.
    tick(12'd320, 12'd240);
    tick(12'd320, 12'd240);
    check("search_trk", tracking, 1'b0);
    pixel("search_pass", 12'd320, 12'd240, PIX);

    // An invalid tick between two valid ones clears the hit counter.
    tick(12'd100, 12'd200);
    tick(12'd320, 12'd240);
    tick(12'd100, 12'd200);
    check("hit_clear_trk", tracking, 1'b0);
    tick(12'd100, 12'd200);
    check_marker("lock", 12'd100, 12'd200, 1'b1);

    pixel("lock_centre",  12'd100, 12'd200, GREEN);
    pixel("lock_arm_end", 12'd116, 12'd200, GREEN);
    pixel("lock_arm_out", 12'd117, 12'd200, PIX);
    pixel("lock_box_r",   12'd132, 12'd200, GREEN);
    pixel("lock_box_out", 12'd133, 12'd200, PIX);
    pixel("lock_arm_up",  12'd100, 12'd184, GREEN);
    pixel("lock_arm_up2", 12'd100, 12'd183, PIX);
    pixel("lock_corner",  12'd132, 12'd232, GREEN);

    // Centre changes away from the tick must not move the marker.
    @(negedge pclk); center_h = 12'd50; center_v = 12'd50; Hcnt = 12'd3; Vcnt = 12'd0;
    @(posedge pclk); #1;
    check("no_tick_mh", marker_h, 12'd100);

    // IIR smoothing toward (200,200).
    tick(12'd200, 12'd200); check_marker("iir1", 12'd125, 12'd200, 1'b1);
    tick(12'd200, 12'd200); check_marker("iir2", 12'd143, 12'd200, 1'b1);
    tick(12'd200, 12'd200); check_marker("iir3", 12'd157, 12'd200, 1'b1);

    // HOLD: yellow crosshair only, marker frozen.
    tick(12'd320, 12'd240);
    check_marker("hold", 12'd157, 12'd200, 1'b1);
    pixel("hold_centre",  12'd157, 12'd200, YELLOW);
    pixel("hold_arm",     12'd173, 12'd200, YELLOW);
    pixel("hold_no_box",  12'd189, 12'd200, PIX);
    for (int i = 0; i < 4; i++) tick(12'd320, 12'd240);
    check("hold_miss5_trk", tracking, 1'b1);
    tick(12'd200, 12'd200);
    check_marker("relock", 12'd167, 12'd200, 1'b1);
    pixel("relock_box", 12'd199, 12'd200, GREEN);

    // Miss counter restarted on relock: needs all 8 misses to drop out.
    for (int i = 0; i < 7; i++) tick(12'd320, 12'd240);
    check("miss7_trk", tracking, 1'b1);
    tick(12'd320, 12'd240);
    check("miss8_trk", tracking, 1'b0);
    pixel("lost_pass", 12'd167, 12'd200, PIX);

    // Marker near the right edge: shapes clip at H_ACTIVE.
    tick(12'd630, 12'd3);
    tick(12'd630, 12'd3);
    check_marker("right", 12'd630, 12'd3, 1'b1);
    pixel("right_in",      12'd639, 12'd3, GREEN);
    pixel("right_arm_l",   12'd614, 12'd3, GREEN);
    pixel("right_clip640", 12'd640, 12'd3, PIX);
    pixel("right_clip646", 12'd646, 12'd3, PIX);
    pixel("right_clipbox", 12'd662, 12'd3, PIX);

    // Reset coinciding with a frame tick wins.
    @(negedge pclk);
    rst = 1'b1; Hcnt = 12'd1; Vcnt = 12'd0; center_h = 12'd600; center_v = 12'd3; rgb_in = PIX;
    @(posedge pclk); #1;
    check("rst_tick_rgb", rgb_out, 24'h0);
    check_marker("rst_tick", 12'd320, 12'd240, 1'b0);
    @(negedge pclk); rst = 1'b0; Hcnt = 12'd2;
    @(posedge pclk); #1;
    check("rst_after_pass", rgb_out, PIX);
    pixel("rst_old_marker", 12'd630, 12'd3, PIX);

    // Marker near the top-left corner: no wrap to far edges.
    tick(12'd5, 12'd3);
    tick(12'd5, 12'd3);
    check_marker("corner", 12'd5, 12'd3, 1'b1);
    pixel("corner_left",  12'd0,    12'd3, GREEN);
    pixel("corner_arm",   12'd21,   12'd3, GREEN);
    pixel("corner_out",   12'd22,   12'd3, PIX);
    pixel("corner_top",   12'd5,    12'd0, GREEN);
    pixel("corner_box",   12'd37,   12'd3, GREEN);
    pixel("corner_nowrap", 12'd639, 12'd3, PIX);
    pixel("corner_blank", 12'd4095, 12'd3, PIX);
    pixel("corner_vblank", 12'd5,   12'd500, PIX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
